uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, b_tick pulses per bit period; legal even values 8..32.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked per frame; legal 1 or 2.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 b_tick  input  1  oversample strobe, one clk wide, OVERSAMPLE per bit period.
REQ-008 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-009 rx_data  output  DATA_BITS  last received word, right-justified.
REQ-010 rx_busy  output  1  high from start-bit detection until frame end or false-start abort.
REQ-011 rx_done  output  1  one-clk pulse marking a completed frame.
REQ-012 parity_err  output  1  parity mismatch on last completed frame; 0 when PARITY=0.
REQ-013 frame_err  output  1  any checked stop bit sampled low on last completed frame.
REQ-014 break_det  output  1  last completed frame had all data, parity and stop bits low.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-017 IDLE: b_tick ignored; rx_s==0 -> START, tick count cleared, bit count cleared, rx_busy=1 next cycle.
REQ-018 START: count b_tick; on the tick where count reaches OVERSAMPLE/2-1, rx_s==0 -> DATA with count cleared, rx_s==1 -> IDLE with rx_busy=0 and no rx_done (false start).
REQ-019 DATA: on the tick where count reaches OVERSAMPLE-1, shift rx_s into the MSB of an internal DATA_BITS shift register (LSB-first line order), clear count; after DATA_BITS samples -> PARITY or STOP.
REQ-020 PARITY: sample at count OVERSAMPLE-1; even mode error when XOR of data and parity bit is 1, odd mode error when it is 0.
REQ-021 STOP: sample each stop bit at count OVERSAMPLE-1; any low sample sets the pending frame error; after STOP_BITS samples -> IDLE.
REQ-022 On the clk edge following the final stop sample: rx_data, parity_err, frame_err, break_det SHALL update together, rx_done=1 for exactly one cycle, rx_busy=0.
REQ-023 rx_data and all error flags SHALL hold their values between rx_done pulses; the shift register SHALL not be visible on rx_data mid-frame.
REQ-024 An error in one frame SHALL not suppress rx_done; data is still delivered.
REQ-025 break_det=1 implies frame_err=1; parity_err follows normal rules during a break.
REQ-026 If rx_s falls in the same cycle the FSM returns to IDLE, the next frame SHALL be detected on the following cycle, with no lost start bit.
REQ-027 Tick and bit counters SHALL be sized for the parameter maxima and SHALL never wrap within a frame.

Reset
REQ-028 While rst_n=0, the FSM SHALL be in IDLE, all counters 0, synchronizer flops 1, rx_data 0, and rx_busy, rx_done, parity_err, frame_err and break_det 0.
REQ-029 Assertion of rst_n mid-frame SHALL abort the frame immediately, with no rx_done; after release the block waits for a new falling edge on rx_s.

Verification
REQ-030 Defaults (8N1, OS=16): frame 0x55 -> one rx_done pulse, rx_data=0x55, all error flags 0, rx_busy low after done.
REQ-031 rx low for 4 b_ticks then high -> no rx_done, rx_busy returns to 0, rx_data unchanged.
REQ-032 PARITY=1: 0xA3 sent with parity bit 1 (wrong) -> rx_data=0xA3, parity_err=1; resend with parity 0 -> parity_err=0.
REQ-033 DATA_BITS=7, STOP_BITS=2: 0x41 with second stop bit low -> rx_data=0x41, frame_err=1, break_det=0.
REQ-034 Line held low for a full frame (8N1) -> rx_data=0x00, frame_err=1, break_det=1.
REQ-035 rst_n pulsed low during bit 4 of 0xFF, then 0x3C sent -> exactly one rx_done, for rx_data=0x3C.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: oversampled start/data/parity/stop sampling
// with parity, framing and break detection, results latched per frame.
module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_busy,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // Counters sized for OVERSAMPLE=32 and DATA_BITS=9 so they never wrap.
    localparam logic [4:0] HalfLast  = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0] BitLast   = 5'(OVERSAMPLE - 1);
    localparam logic [3:0] DataLast  = 4'(DATA_BITS - 1);
    localparam logic [3:0] StopLast  = 4'(STOP_BITS - 1);
    localparam bit         HasParity = (PARITY != 0);

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [4:0]           tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 high_seen_q, high_seen_d;
    logic                 frame_pend_q, frame_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q, break_d;
    logic                 done_q, done_d;
    logic                 sample;
    logic                 parity_calc;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: counters, shift register, pending flags, frame results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            high_seen_q  <= 1'b0;
            frame_pend_q <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            high_seen_q  <= high_seen_d;
            frame_pend_q <= frame_pend_d;
            rx_data_q    <= rx_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_q      <= break_d;
            done_q       <= done_d;
        end
    end

    // Parity verdict for the frame being completed.
    always_comb begin
        parity_calc = 1'b0;
        if (PARITY == 1) begin
            parity_calc = (^shreg_q) ^ par_bit_q;
        end else if (PARITY == 2) begin
            parity_calc = ~((^shreg_q) ^ par_bit_q);
        end
    end

    // Next-state and datapath update; samples are taken mid-bit.
    always_comb begin
        sample       = b_tick && (tick_q == BitLast);
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        high_seen_d  = high_seen_q;
        frame_pend_d = frame_pend_q;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_d      = break_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d      = StStart;
                    tick_d       = '0;
                    bit_d        = '0;
                    high_seen_d  = 1'b0;
                    frame_pend_d = 1'b0;
                end
            end
            StStart: begin
                if (b_tick) begin
                    if (tick_q == HalfLast) begin
                        tick_d  = '0;
                        // A high line at mid-start is a glitch, not a frame.
                        state_d = rx_s_q ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            StData: begin
                if (sample) begin
                    shreg_d     = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    high_seen_d = high_seen_q | rx_s_q;
                    tick_d      = '0;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = HasParity ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else if (b_tick) begin
                    tick_d = tick_q + 5'd1;
                end
            end
            StParity: begin
                if (sample) begin
                    par_bit_d   = rx_s_q;
                    high_seen_d = high_seen_q | rx_s_q;
                    tick_d      = '0;
                    state_d     = StStop;
                end else if (b_tick) begin
                    tick_d = tick_q + 5'd1;
                end
            end
            StStop: begin
                if (sample) begin
                    tick_d = '0;
                    if (!rx_s_q) begin
                        frame_pend_d = 1'b1;
                    end
                    high_seen_d = high_seen_q | rx_s_q;
                    if (bit_q == StopLast) begin
                        bit_d        = '0;
                        state_d      = StIdle;
                        done_d       = 1'b1;
                        rx_data_d    = shreg_q;
                        parity_err_d = parity_calc;
                        frame_err_d  = frame_pend_q | ~rx_s_q;
                        break_d      = ~(high_seen_q | rx_s_q);
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else if (b_tick) begin
                    tick_d = tick_q + 5'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: busy whenever a frame is in progress, results from latched flops.
    always_comb begin
        rx_busy    = (state_q != StIdle);
        rx_data    = rx_data_q;
        rx_done    = done_q;
        parity_err = parity_err_q;
        frame_err  = frame_err_q;
        break_det  = break_q;
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 default, 8E1 and 7N2 instances.
module tb_uart_rx_param;

    localparam int BitClks = 64;  // 16 b_ticks, one every 4 clk

    logic clk, rst_n, b_tick;
    logic rx0, rx1, rx2;

    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic busy0, done0, perr0, ferr0, brk0;
    logic busy1, done1, perr1, ferr1, brk1;
    logic busy2, done2, perr2, ferr2, brk2;

    int n_err = 0;
    int n_checks = 0;
    int dcnt0 = 0, dcnt1 = 0, dcnt2 = 0;
    int base;
    logic       mid_busy;
    logic [7:0] mid_data;

    uart_rx_param u_dut0 (
        .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .rx(rx0), .rx_data(data0),
        .rx_busy(busy0), .rx_done(done0), .parity_err(perr0), .frame_err(ferr0),
        .break_det(brk0)
    );

    uart_rx_param #(.PARITY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .rx(rx1), .rx_data(data1),
        .rx_busy(busy1), .rx_done(done1), .parity_err(perr1), .frame_err(ferr1),
        .break_det(brk1)
    );

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .rx(rx2), .rx_data(data2),
        .rx_busy(busy2), .rx_done(done2), .parity_err(perr2), .frame_err(ferr2),
        .break_det(brk2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        b_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            b_tick = 1'b1;
            @(negedge clk);
            b_tick = 1'b0;
        end
    end

    // Count rx_done pulses; a stretched pulse shows up as an extra count.
    always @(posedge clk) begin
        if (done0) dcnt0 <= dcnt0 + 1;
        if (done1) dcnt1 <= dcnt1 + 1;
        if (done2) dcnt2 <= dcnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic b);
        case (which)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
    endtask

    // Send n line bits LSB first; the last bit lasts last_clks, then the line idles.
    task automatic send_line(input logic [15:0] bits, input int n, input int which,
                             input int last_clks);
        for (int i = 0; i < n; i++) begin
            drive(which, bits[i]);
            repeat (32) @(negedge clk);
            if (i == 4) begin
                mid_busy = busy0;
                mid_data = data0;
            end
            repeat (((i == n - 1) ? last_clks : BitClks) - 32) @(negedge clk);
        end
        drive(which, 1'b1);
        repeat (3 * BitClks) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", 32'(data0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_done", 32'(done0), 32'h0);
        check("rst_perr", 32'(perr0), 32'h0);
        check("rst_ferr", 32'(ferr0), 32'h0);
        check("rst_brk", 32'(brk0), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0x55
        base = dcnt0;
        send_line({6'b0, 1'b1, 8'h55, 1'b0}, 10, 0, BitClks);
        check("f55_mid_busy", 32'(mid_busy), 32'h1);
        check("f55_mid_data", 32'(mid_data), 32'h0);
        check("f55_done", 32'(dcnt0 - base), 32'h1);
        check("f55_data", 32'(data0), 32'h55);
        check("f55_perr", 32'(perr0), 32'h0);
        check("f55_ferr", 32'(ferr0), 32'h0);
        check("f55_brk", 32'(brk0), 32'h0);
        check("f55_busy", 32'(busy0), 32'h0);

        // False start: 4 ticks low
        base = dcnt0;
        rx0 = 1'b0;
        repeat (16) @(negedge clk);
        check("fs_busy_on", 32'(busy0), 32'h1);
        rx0 = 1'b1;
        repeat (200) @(negedge clk);
        check("fs_done", 32'(dcnt0 - base), 32'h0);
        check("fs_busy", 32'(busy0), 32'h0);
        check("fs_data", 32'(data0), 32'h55);

        // Even parity, 0xA3 has four ones: parity bit 1 is wrong, 0 is right
        base = dcnt1;
        send_line({5'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11, 1, BitClks);
        check("pe_bad_done", 32'(dcnt1 - base), 32'h1);
        check("pe_bad_data", 32'(data1), 32'hA3);
        check("pe_bad_perr", 32'(perr1), 32'h1);
        check("pe_bad_ferr", 32'(ferr1), 32'h0);
        base = dcnt1;
        send_line({5'b0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11, 1, BitClks);
        check("pe_ok_done", 32'(dcnt1 - base), 32'h1);
        check("pe_ok_data", 32'(data1), 32'hA3);
        check("pe_ok_perr", 32'(perr1), 32'h0);

        // 7N2 0x41: clean frame, then second stop bit low (held just past mid-bit)
        send_line({6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, 2, BitClks);
        check("s2_ok_data", 32'(data2), 32'h41);
        check("s2_ok_ferr", 32'(ferr2), 32'h0);
        base = dcnt2;
        send_line({6'b0, 1'b0, 1'b1, 7'h41, 1'b0}, 10, 2, 44);
        check("s2_bad_done", 32'(dcnt2 - base), 32'h1);
        check("s2_bad_data", 32'(data2), 32'h41);
        check("s2_bad_ferr", 32'(ferr2), 32'h1);
        check("s2_bad_brk", 32'(brk2), 32'h0);
        check("s2_bad_busy", 32'(busy2), 32'h0);

        // Break: line low for a whole 8N1 frame
        base = dcnt0;
        send_line(16'h0000, 10, 0, 44);
        check("brk_done", 32'(dcnt0 - base), 32'h1);
        check("brk_data", 32'(data0), 32'h00);
        check("brk_ferr", 32'(ferr0), 32'h1);
        check("brk_det", 32'(brk0), 32'h1);
        check("brk_perr", 32'(perr0), 32'h0);

        // Reset during bit 4 of 0xFF, then 0x3C
        base = dcnt0;
        rx0 = 1'b0;
        repeat (BitClks) @(negedge clk);
        rx0 = 1'b1;
        repeat (4 * BitClks + 32) @(negedge clk);
        check("rr_busy_pre", 32'(busy0), 32'h1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rr_busy", 32'(busy0), 32'h0);
        check("rr_data", 32'(data0), 32'h0);
        rst_n = 1'b1;
        repeat (32 + 4 * BitClks) @(negedge clk);
        check("rr_idle_busy", 32'(busy0), 32'h0);
        send_line({6'b0, 1'b1, 8'h3C, 1'b0}, 10, 0, BitClks);
        check("rr_done", 32'(dcnt0 - base), 32'h1);
        check("rr_data3c", 32'(data0), 32'h3C);
        check("rr_ferr", 32'(ferr0), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
